board_fill_ctrl: RTL and testbench

Write-sequencer for the 20x15 game-board tile RAM behind the cursor/VGA datapath. On a start pulse it sweeps every cell with pseudo-random tile values from an internal 8-bit LFSR. Afterwards it services single-cell player writes at the cursor position. Player clicks arriving mid-sweep are held in a one-entry buffer. It is the single writer of the board RAM write port.

---
 rtl/board_pkg.sv | 20 ++
 rtl/board_lfsr.sv | 20 ++
 rtl/board_fill_ctrl.sv | 153 +++++++++++++++
 tb/tb_board_fill_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants, FSM state type and LFSR tap rule for the board fill sequencer.
package board_pkg;

    localparam int COLS   = 20;
    localparam int ROWS   = 15;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    // Right shift with the new MSB taken from bits 4,3,2.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[4] ^ l[3] ^ l[2], l[7:1]};
    endfunction

endpackage

// File: rtl/board_lfsr.sv
// 8-bit tile-value LFSR: loads SEED on reset and steps only when adv is high.
module board_lfsr
    import board_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h1C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [7:0] lfsr
);

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= SEED;
        else if (adv)
            lfsr <= lfsr_next(lfsr);
    end

endmodule

// File: rtl/board_fill_ctrl.sv
// Single writer of the board tile RAM: random sweep on start, then cursor clicks.
// Optional BOARD_FILL_NO_EMPTY_EN maps zero fill values to 1.
module board_fill_ctrl
    import board_pkg::*;
#(
    parameter int          COLS   = 20,
    parameter int          ROWS   = 15,
    parameter int          DATA_W = 4,
    parameter logic [7:0]  SEED   = 8'h1C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        cell_x,
    input  logic [4:0]        cell_y,
    input  logic              click,
    input  logic [DATA_W-1:0] click_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              click_ack,
    output logic              click_drop
);

    localparam logic [ADDR_W-1:0] NCELLS = ADDR_W'(COLS * ROWS);

    state_t              state;
    logic [ADDR_W-1:0]   count;
    logic [7:0]          lfsr;
    logic                pend_vld;
    logic [ADDR_W-1:0]   pend_addr;
    logic [DATA_W-1:0]   pend_data;

    logic                click_ok;
    logic [ADDR_W-1:0]   click_addr;
    logic                fill_go;
    logic                lfsr_adv;
    logic                buf_phase;
    logic [DATA_W-1:0]   fill_val;

    assign click_ok   = click && (ADDR_W'(cell_x) < ADDR_W'(COLS))
                             && (ADDR_W'(cell_y) < ADDR_W'(ROWS));
    assign click_addr = ADDR_W'(cell_y) * ADDR_W'(COLS) + ADDR_W'(cell_x);
    assign fill_go    = (state == FILL) && (count < NCELLS);
    assign lfsr_adv   = start || fill_go;
    // Clicks seen while a sweep write is being issued go through the one-entry buffer.
    assign buf_phase  = start || fill_go;

`ifdef BOARD_FILL_NO_EMPTY_EN
    assign fill_val = (lfsr[DATA_W-1:0] == '0) ? DATA_W'(1) : lfsr[DATA_W-1:0];
`else
    assign fill_val = lfsr[DATA_W-1:0];
`endif

    board_lfsr #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (lfsr_adv),
        .lfsr (lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            click_ack  <= 1'b0;
            click_drop <= 1'b0;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            we         <= 1'b0;
            done       <= 1'b0;
            click_ack  <= 1'b0;
            click_drop <= 1'b0;

            if (start) begin
                state <= FILL;
                busy  <= 1'b1;
                we    <= 1'b1;
                waddr <= '0;
                wdata <= fill_val;
                count <= ADDR_W'(1);
            end else begin
                case (state)
                    IDLE: begin
                        if (click)
                            click_drop <= 1'b1;
                    end
                    FILL: begin
                        if (fill_go) begin
                            we    <= 1'b1;
                            waddr <= count;
                            wdata <= fill_val;
                            count <= count + 1'b1;
                        end else begin
                            // Done cycle: flush the buffered click, else take a fresh one.
                            state <= RUN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            count <= '0;
                            if (pend_vld) begin
                                we        <= 1'b1;
                                waddr     <= pend_addr;
                                wdata     <= pend_data;
                                click_ack <= 1'b1;
                                pend_vld  <= 1'b0;
                                if (click)
                                    click_drop <= 1'b1;
                            end else if (click_ok) begin
                                we        <= 1'b1;
                                waddr     <= click_addr;
                                wdata     <= click_data;
                                click_ack <= 1'b1;
                            end else if (click) begin
                                click_drop <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (click_ok) begin
                            we        <= 1'b1;
                            waddr     <= click_addr;
                            wdata     <= click_data;
                            click_ack <= 1'b1;
                        end else if (click) begin
                            click_drop <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (buf_phase && click) begin
                if (click_ok && !pend_vld) begin
                    pend_vld  <= 1'b1;
                    pend_addr <= click_addr;
                    pend_data <= click_data;
                end else begin
                    click_drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_fill_ctrl.sv
// Directed self-checking bench for board_fill_ctrl (second instance uses SEED 8'h10).
module tb_board_fill_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, click;
    logic [4:0] cell_x, cell_y;
    logic [3:0] click_data;
    logic       we, busy, done, click_ack, click_drop;
    logic [8:0] waddr;
    logic [3:0] wdata;
    logic       we2, busy2, done2, click_ack2, click_drop2;
    logic [8:0] waddr2;
    logic [3:0] wdata2;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] m;

`ifdef BOARD_FILL_NO_EMPTY_EN
    localparam logic [3:0] ZERO_SEED_EXP = 4'h1;
`else
    localparam logic [3:0] ZERO_SEED_EXP = 4'h0;
`endif

    always #5 clk = ~clk;

    board_fill_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .cell_x(cell_x), .cell_y(cell_y),
        .click(click), .click_data(click_data), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .click_ack(click_ack), .click_drop(click_drop)
    );

    board_fill_ctrl #(.SEED(8'h10)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .cell_x(cell_x), .cell_y(cell_y),
        .click(click), .click_data(click_data), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .busy(busy2), .done(done2), .click_ack(click_ack2), .click_drop(click_drop2)
    );

    function automatic logic [7:0] nxt(input logic [7:0] l);
        return {l[4] ^ l[3] ^ l[2], l[7:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start in cycle 0, optional restart in cycle rs, optional clicks at cycles 50/60.
    task automatic run_sweep(input int rs, input bit clicks, input bit first);
        int  base, done_c, ndone, ea;
        bit  fw;
        ndone  = 0;
        base   = (rs > 0) ? rs + 1 : 1;
        done_c = base + 300;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        for (int c = 1; c <= done_c + 3; c++) begin
            fw = 1'b0;
            ea = 0;
            if (rs > 0 && c <= rs) begin
                fw = 1'b1; ea = c - 1;
            end else if (c >= base && c < done_c) begin
                fw = 1'b1; ea = c - base;
            end
            if (fw) begin
                chk("fill_we", we, 1);
                chk("fill_waddr", waddr, ea);
                chk("fill_wdata", wdata, m[3:0]);
                chk("fill_busy", busy, 1);
                chk("fill_ack", click_ack, 0);
                m = nxt(m);
            end else if (c == done_c) begin
                chk("done_busy", busy, 0);
                chk("done_we", we, clicks);
                chk("done_ack", click_ack, clicks);
                if (clicks) begin
                    chk("done_waddr", waddr, 21);
                    chk("done_wdata", wdata, 9);
                end
            end else begin
                chk("post_we", we, 0);
                chk("post_busy", busy, 0);
            end
            chk("done_pulse", done, (c == done_c));
            if (done) ndone++;
            if (clicks && c == 61) chk("buf_full_drop", click_drop, 1);
            if (first) begin
                if (c == 1) begin
                    chk("addr0_val", wdata, 4'hC);
                    chk("zero_seed_val", wdata2, ZERO_SEED_EXP);
                end
                if (c == 2) chk("addr1_val", wdata, 4'hE);
                if (c == 3) chk("addr2_val", wdata, 4'h7);
            end
            start      = (c == rs);
            click      = clicks && (c == 50 || c == 60);
            cell_x     = (c == 50) ? 5'd1 : 5'd5;
            cell_y     = (c == 50) ? 5'd1 : 5'd5;
            click_data = (c == 50) ? 4'd9 : 4'd3;
            tick;
        end
        start = 1'b0;
        click = 1'b0;
        chk("done_count", ndone, 1);
    endtask

    task automatic do_click(input logic [4:0] x, input logic [4:0] y, input logic [3:0] d);
        cell_x = x; cell_y = y; click_data = d; click = 1'b1;
        tick;
        click = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; click = 1'b0;
        cell_x = '0; cell_y = '0; click_data = '0;
        m = 8'h1C;
        tick; tick;
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack", click_ack, 0);
        chk("rst_drop", click_drop, 0);
        rst = 1'b0;
        tick;

        do_click(5'd2, 5'd2, 4'd3);
        chk("idle_drop", click_drop, 1);
        chk("idle_we", we, 0);
        tick;
        chk("idle_drop_clr", click_drop, 0);

        run_sweep(0, 1'b0, 1'b1);

        do_click(5'd3, 5'd2, 4'd5);
        chk("run_we", we, 1);
        chk("run_waddr", waddr, 43);
        chk("run_wdata", wdata, 5);
        chk("run_ack", click_ack, 1);
        tick;
        chk("run_ack_clr", click_ack, 0);
        do_click(5'd20, 5'd0, 4'd1);
        chk("x_oob_drop", click_drop, 1);
        chk("x_oob_we", we, 0);
        do_click(5'd0, 5'd15, 4'd1);
        chk("y_oob_drop", click_drop, 1);
        chk("y_oob_we", we, 0);
        do_click(5'd19, 5'd14, 4'd7);
        chk("max_waddr", waddr, 299);
        chk("max_ack", click_ack, 1);
        tick;

        run_sweep(0, 1'b1, 1'b0);
        run_sweep(100, 1'b0, 1'b0);

        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_we", we, 0);
        chk("midrst_waddr", waddr, 0);
        do_click(5'd1, 5'd1, 4'd2);
        chk("midrst_idle_drop", click_drop, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("midrst_seed_val", wdata, 4'hC);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
